// File: rtl/usart_rx_if.sv
// Host-side bus of the USART receiver: received byte, status flags and read strobe.
// The master drives read; the receiver (slave) drives everything else.
interface usart_rx_if;
    logic       read;
    logic [7:0] data_out;
    logic       data_ready;
    logic       framing_error;
    logic       overrun_error;

    modport master (
        output read,
        input  data_out,
        input  data_ready,
        input  framing_error,
        input  overrun_error
    );

    modport slave (
        input  read,
        output data_out,
        output data_ready,
        output framing_error,
        output overrun_error
    );
endinterface

// File: rtl/usart_rx.sv
// 8N1 asynchronous serial receiver with a one-byte holding register,
// sticky framing/overrun flags and a host read strobe.
module usart_rx #(
    parameter int unsigned CLOCKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_pin,
    usart_rx_if.slave  host
);

    localparam int unsigned    CntW    = $clog2(CLOCKS_PER_BIT);
    localparam logic [CntW-1:0] CntOne  = CntW'(1);
    localparam logic [CntW-1:0] CntHalf = CntW'(CLOCKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] CntLast = CntW'(CLOCKS_PER_BIT - 1);

    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            ready_q, ready_d;
    logic            ferr_q, ferr_d;
    logic            oerr_q, oerr_d;
    logic            sync1_q, sync2_q;
    logic            rxs;
    logic            complete;
    logic            stop_bad;

    assign rxs = sync2_q;

    // Synchroniser idles high so reset never looks like a start bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx_pin;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            ferr_q  <= 1'b0;
            oerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            ferr_q  <= ferr_d;
            oerr_q  <= oerr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + CntOne;
        idx_d    = idx_q;
        shift_d  = shift_q;
        complete = 1'b0;
        stop_bad = 1'b0;
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rxs) state_d = StStart;
            end
            StStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxs ? StIdle : StData;
                end
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d   = '0;
                    shift_d = {rxs, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) state_d = StStop;
                end
            end
            StStop: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (rxs) begin
                        complete = 1'b1;
                        state_d  = StIdle;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = StBreak;
                    end
                end
            end
            StBreak: begin
                cnt_d = '0;
                if (rxs) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // A completion in the same cycle as read wins over the read's clear of data_ready.
    always_comb begin
        data_d  = data_q;
        ready_d = ready_q;
        ferr_d  = ferr_q;
        oerr_d  = oerr_q;
        if (host.read) begin
            ready_d = 1'b0;
            ferr_d  = 1'b0;
            oerr_d  = 1'b0;
        end
        if (complete) begin
            ready_d = 1'b1;
            if (!ready_q || host.read) begin
                data_d = shift_q;
            end else begin
                oerr_d = 1'b1;
            end
        end
        if (stop_bad) ferr_d = 1'b1;
    end

    assign host.data_out      = data_q;
    assign host.data_ready    = ready_q;
    assign host.framing_error = ferr_q;
    assign host.overrun_error = oerr_q;

endmodule
